// File: rtl/limb_pkg.sv
// ---------------------------------------------------------------------------
// limb_pkg
// Shared definitions for the instruction prefetch buffer: bus transfer-type
// encodings, the fetch FSM state type, the buffered entry layout and the
// AL / NOP instruction constants.
// ---------------------------------------------------------------------------
package limb_pkg;

  // Memory bus transfer types
  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] TRANS_NSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ  = 2'b11;

  // Condition code "always" and the canonical no-op (mov r0, r0)
  localparam logic [3:0]  AL  = 4'hE;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    ST_NSEQ = 2'd0,
    ST_SEQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        abort;
    logic [31:0] pc;
    logic [31:0] instr;
  } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// ---------------------------------------------------------------------------
// prefetch_fifo
// DEPTH-entry synchronous FIFO holding {abort, pc, instr} fetch results.
// The head entry is read from registered storage, so nothing written in a
// cycle is visible at the output before the following cycle.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   i_push   in   write i_data at the tail
//   i_data   in   entry to write
//   i_pop    in   drop the head entry (ignored when empty)
//   i_clear  in   drop all entries; overrides push and pop
//   o_head   out  head entry (all zero when empty)
//   o_valid  out  at least one entry present
//   o_count  out  number of entries held
// ---------------------------------------------------------------------------
module prefetch_fifo
  import limb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  pf_entry_t        i_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output pf_entry_t        o_head,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  pf_entry_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  // A push into a full FIFO is fine as long as the head leaves in the same cycle.
  assign w_push = i_push && (w_pop || (r_count != CNT_W'(DEPTH)));

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instruction_prefetch_buffer
// Fetches consecutive instruction words from a pipelined memory (data one
// cycle after the request) into a small FIFO and presents them to decode.
// A flush redirects fetching to a branch target and drops everything queued
// or in flight.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   addr         out  registered fetch word address
//   trans        out  registered transfer type (00 idle, 10 nseq, 11 seq)
//   write        out  memory write strobe, always 0
//   rdata        in   read data for the previous cycle's request
//   abort        in   memory abort, qualified with rdata
//   flush        in   redirect pulse from execute
//   flush_addr   in   redirect target word address
//   instr_o      out  head instruction
//   instr_pc     out  word address of instr_o
//   instr_abort  out  head was fetched with abort set
//   instr_valid  out  head entry present
//   instr_ready  in   decode accepts the head entry
//
// Fetch FSM (state describes the transfer currently on the bus)
//   state | meaning
//   NSEQ  | non-sequential request at a new address (reset, redirect)
//   SEQ   | sequential request at previous address + 1
//   HOLD  | no credit, bus idle, addr holds the last requested address
// ---------------------------------------------------------------------------
module instruction_prefetch_buffer
  import limb_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] addr,
  output logic [1:0]  trans,
  output logic        write,
  input  logic [31:0] rdata,
  input  logic        abort,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc,
  output logic        instr_abort,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     r_state;
  logic [31:0]      r_addr;
  logic [1:0]       r_trans;
  logic             r_started;
  logic             r_pend;
  logic [31:0]      r_pend_pc;

  pf_entry_t        w_din;
  pf_entry_t        w_head;
  logic             w_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_in_flight;
  logic             w_credit;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_next;

  // Responses to requests made before or during a flush never reach the FIFO.
  assign w_push = r_pend && !flush;
  assign w_pop  = w_valid && instr_ready && !flush;
  assign w_din  = {abort, r_pend_pc, rdata};

  // After this edge the request now on the bus is the only one still in flight.
  assign w_in_flight  = (r_state != ST_HOLD);
  assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_credit     = (w_count_next + CNT_W'(w_in_flight)) < CNT_W'(DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_NSEQ;
      r_trans   <= TRANS_IDLE;
      r_addr    <= RESET_ADDR;
      r_started <= 1'b0;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_pend    <= (r_trans != TRANS_IDLE) && !flush;
      r_pend_pc <= r_addr;
      if (flush) begin
        r_started <= 1'b1;
        r_state   <= ST_NSEQ;
        r_trans   <= TRANS_NSEQ;
        r_addr    <= flush_addr;
      end else if (!r_started) begin
        // First edge after reset: put the reset-address request on the bus.
        r_started <= 1'b1;
        r_state   <= ST_NSEQ;
        r_trans   <= TRANS_NSEQ;
      end else begin
        unique case (r_state)
          ST_NSEQ, ST_SEQ, ST_HOLD: begin
            if (w_credit) begin
              r_state <= ST_SEQ;
              r_trans <= TRANS_SEQ;
              r_addr  <= r_addr + 32'd1;
            end else begin
              r_state <= ST_HOLD;
              r_trans <= TRANS_IDLE;
            end
          end
          default: begin
            r_state <= ST_HOLD;
            r_trans <= TRANS_IDLE;
          end
        endcase
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_din),
    .i_pop   (w_pop),
    .i_clear (flush),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign addr        = r_addr;
  assign trans       = r_trans;
  assign write       = 1'b0;
  assign instr_o     = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign instr_abort = w_head.abort;
  assign instr_valid = w_valid;

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
module tb_instruction_prefetch_buffer;
  import limb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr;
  logic [1:0]  trans;
  logic        write;
  logic [31:0] rdata = '0;
  logic        abort = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_addr = '0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc;
  logic        instr_abort;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  // Second instance starting just below the 32-bit wrap point
  logic [31:0] addr2;
  logic [1:0]  trans2;
  logic        write2;
  logic [31:0] rdata2 = '0;
  logic        abort2 = 1'b0;
  logic        flush2 = 1'b0;
  logic [31:0] flush_addr2 = '0;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic        iabort2;
  logic        valid2;
  logic        ready2 = 1'b1;

  always #5 clk = ~clk;

  instruction_prefetch_buffer #(.DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .trans(trans), .write(write),
    .rdata(rdata), .abort(abort), .flush(flush), .flush_addr(flush_addr),
    .instr_o(instr_o), .instr_pc(instr_pc), .instr_abort(instr_abort),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  instruction_prefetch_buffer #(.DEPTH(DEPTH), .RESET_ADDR(32'hFFFF_FFFE)) dut_wrap (
    .clk(clk), .reset(reset), .addr(addr2), .trans(trans2), .write(write2),
    .rdata(rdata2), .abort(abort2), .flush(flush2), .flush_addr(flush_addr2),
    .instr_o(instr2), .instr_pc(pc2), .instr_abort(iabort2),
    .instr_valid(valid2), .instr_ready(ready2)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_pops = 0;
  logic [31:0] salt = '0;
  logic        abort_en = 1'b0;

  // Reference model of the delivered and requested streams
  logic [31:0] m_target;
  logic [31:0] m_req_next;
  logic [31:0] m_pop_next;
  logic        m_redirect;
  logic        m_after_flush;
  int          m_issued;
  int          m_popped;

  function automatic logic exp_abort(input logic [31:0] pc);
    return abort_en && (pc[2:0] == 3'd5);
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset(input logic [31:0] target);
    m_target      = target;
    m_req_next    = target;
    m_pop_next    = target;
    m_redirect    = 1'b1;
    m_after_flush = 1'b0;
    m_issued      = 0;
    m_popped      = 0;
  endtask

  // Called once per cycle at the falling edge, after inputs are settled.
  task automatic model_step();
    if (m_after_flush) begin
      chk("flush_redirect", {trans, addr, instr_valid}, {2'b10, m_target, 1'b0});
      m_after_flush = 1'b0;
    end
    if (trans != 2'b00) begin
      if (trans == 2'b10) begin
        chk("nseq_addr", {m_redirect, addr}, {1'b1, m_target});
        m_redirect = 1'b0;
        m_issued   = 0;
      end else begin
        chk("seq_addr", {m_redirect, trans, addr}, {1'b0, 2'b11, m_req_next});
      end
      m_req_next = addr + 32'd1;
      m_issued++;
      chk("credit", 128'(m_issued - m_popped > DEPTH), 128'd0);
    end
    if (instr_valid) begin
      chk("head", {instr_pc, instr_o, instr_abort},
          {m_pop_next, m_pop_next ^ salt, exp_abort(m_pop_next)});
    end
    if (flush) begin
      m_target      = flush_addr;
      m_redirect    = 1'b1;
      m_after_flush = 1'b1;
      m_popped      = 0;
      m_pop_next    = flush_addr;
    end else if (instr_valid && instr_ready) begin
      m_pop_next = m_pop_next + 32'd1;
      m_popped++;
      n_pops++;
    end
  endtask

  task automatic cyc(input logic rdy, input logic fl, input logic [31:0] fa);
    @(posedge clk);
    #1;
    instr_ready = rdy;
    flush       = fl;
    flush_addr  = fa;
    @(negedge clk);
    model_step();
  endtask

  task automatic do_reset(input logic [31:0] target);
    @(posedge clk);
    #1;
    reset = 1'b1;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset(target);
  endtask

  // Memory for the main instance: data = addr ^ salt, abort on addr[2:0]==5 when enabled
  initial begin
    logic        v;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      v = (trans != 2'b00);
      a = addr;
      @(posedge clk);
      #1;
      rdata = v ? (a ^ salt) : NOP;
      abort = v && abort_en && (a[2:0] == 3'd5);
    end
  end

  initial begin
    logic        v;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      v = (trans2 != 2'b00);
      a = addr2;
      @(posedge clk);
      #1;
      rdata2 = v ? a : {AL, 28'h0BAD_BAD};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          rst;
    bit          rdy;
    logic [1:0]  tr;
    logic [31:0] ad;
    bit          v;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic        seen5;
    logic        seen6;
    logic        got;
    logic        rdy;
    logic        fl;
    logic        prev_fl;
    logic [31:0] fa;
    logic [1:0]  w_tr [5];
    logic [31:0] w_ad [5];
    int          pops0;

    // Reset release, ready high: stream 0,1,2,...
    tbl[0]  = '{1'b1, 1'b1, 2'b10, 32'd0, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 2'b11, 32'd1, 1'b0, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 2'b11, 32'd2, 1'b1, 32'd0};
    tbl[3]  = '{1'b0, 1'b1, 2'b11, 32'd3, 1'b1, 32'd1};
    tbl[4]  = '{1'b0, 1'b1, 2'b11, 32'd4, 1'b1, 32'd2};
    tbl[5]  = '{1'b0, 1'b1, 2'b11, 32'd5, 1'b1, 32'd3};
    // Ready low: four requests then idle; first pop frees credit for addr 4
    tbl[6]  = '{1'b1, 1'b0, 2'b10, 32'd0, 1'b0, 32'd0};
    tbl[7]  = '{1'b0, 1'b0, 2'b11, 32'd1, 1'b0, 32'd0};
    tbl[8]  = '{1'b0, 1'b0, 2'b11, 32'd2, 1'b1, 32'd0};
    tbl[9]  = '{1'b0, 1'b0, 2'b11, 32'd3, 1'b1, 32'd0};
    tbl[10] = '{1'b0, 1'b0, 2'b00, 32'd3, 1'b1, 32'd0};
    tbl[11] = '{1'b0, 1'b0, 2'b00, 32'd3, 1'b1, 32'd0};
    tbl[12] = '{1'b0, 1'b1, 2'b00, 32'd3, 1'b1, 32'd0};
    tbl[13] = '{1'b0, 1'b1, 2'b11, 32'd4, 1'b1, 32'd1};
    tbl[14] = '{1'b0, 1'b1, 2'b11, 32'd5, 1'b1, 32'd2};
    tbl[15] = '{1'b0, 1'b1, 2'b11, 32'd6, 1'b1, 32'd3};
    tbl[16] = '{1'b0, 1'b1, 2'b11, 32'd7, 1'b1, 32'd4};

    // Values held during reset
    @(posedge clk);
    #1;
    chk("reset_state", {addr, trans, write, instr_valid, instr_o, instr_pc, instr_abort},
        {32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
    chk("reset_state_wrap", {addr2, trans2, valid2}, {32'hFFFF_FFFE, 2'b00, 1'b0});

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) do_reset(32'h0);
      cyc(tbl[i].rdy, 1'b0, 32'h0);
      chk($sformatf("vec%0d_bus", i), {trans, addr, write, instr_valid},
          {tbl[i].tr, tbl[i].ad, 1'b0, tbl[i].v});
      if (tbl[i].v) chk($sformatf("vec%0d_head", i), {instr_pc, instr_o}, {tbl[i].pc, tbl[i].pc});
    end

    // Flush while the buffer is committed full (3 held + 1 response arriving)
    do_reset(32'h0);
    repeat (4) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h40);
    cyc(1'b1, 1'b0, 32'h0);
    chk("flush_next_cycle", {trans, addr, instr_valid}, {2'b10, 32'h40, 1'b0});
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      if (instr_valid) begin
        got = 1'b1;
        chk("flush_first_pc", {instr_pc, instr_o}, {32'h40, 32'h40});
      end
    end
    chk("flush_first_seen", 128'(got), 128'd1);

    // Abort on the response for addr 5
    abort_en = 1'b1;
    do_reset(32'h0);
    seen5 = 1'b0;
    seen6 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      if (instr_valid && instr_pc == 32'd5) begin
        seen5 = 1'b1;
        chk("abort_pc5", 128'(instr_abort), 128'd1);
      end
      if (instr_valid && instr_pc == 32'd6) begin
        seen6 = 1'b1;
        chk("abort_pc6", {instr_abort, instr_o}, {1'b0, 32'd6});
      end
    end
    chk("abort_seen", {seen5, seen6}, 2'b11);
    abort_en = 1'b0;

    // Reset pulsed mid-stream with three entries buffered
    do_reset(32'h0);
    repeat (5) cyc(1'b0, 1'b0, 32'h0);
    chk("pre_reset_valid", 128'(instr_valid), 128'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("reset_immediate", {instr_valid, trans, addr}, {1'b0, 2'b00, 32'h0});
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset(32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("reset_restart", {trans, addr, instr_valid}, {2'b10, 32'h0, 1'b0});

    // Wrap-around from RESET_ADDR = FFFFFFFE
    do_reset(32'h0);
    w_tr[0] = 2'b10; w_ad[0] = 32'hFFFF_FFFE;
    w_tr[1] = 2'b11; w_ad[1] = 32'hFFFF_FFFF;
    w_tr[2] = 2'b11; w_ad[2] = 32'h0000_0000;
    w_tr[3] = 2'b11; w_ad[3] = 32'h0000_0001;
    w_tr[4] = 2'b11; w_ad[4] = 32'h0000_0002;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk($sformatf("wrap_req%0d", k), {trans2, addr2}, {w_tr[k], w_ad[k]});
      if (k >= 2) chk($sformatf("wrap_head%0d", k), {valid2, pc2, instr2},
                      {1'b1, w_ad[k-2], w_ad[k-2]});
    end

    // Randomized traffic against the stream model
    do_reset(32'h0);
    salt     = $urandom;
    abort_en = 1'b1;
    prev_fl  = 1'b0;
    pops0    = n_pops;
    for (int i = 0; i < 1500; i++) begin
      if (((i / 100) % 3) == 0) rdy = ($urandom_range(0, 7) == 0);
      else                      rdy = ($urandom_range(0, 3) != 0);
      fl = !prev_fl && ($urandom_range(0, 39) == 0);
      fa = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
      cyc(rdy, fl, fa);
      prev_fl = fl;
    end
    chk("throughput_low", 128'((n_pops - pops0) < 300), 128'd0);

    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    flush       = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
